instr_fetch_stage: RTL and testbench
====================================

# instr_fetch_stage

Instruction fetch stage for the single-clock MIPS core. Owns the fetch PC, reads 32-bit instructions from the byte-wide instruction memory array, and buffers them in a small prefetch FIFO. Presents them to the decode stage of `main` over a valid/ready handshake. Supports branch/jump redirect with flush, decode back-pressure, and a consecutive-NOP counter for bench termination.

## Interface

- `MEM_BYTES`, 256: instruction memory size in bytes; power of two.
- `FIFO_DEPTH`, 2: prefetch entries; power of two, 2..4.
- `RESET_PC`, 32'h0000_0000: fetch address after reset; word-aligned.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = in reset, 1 = run).
- `instruction_mem`  in  8 x MEM_BYTES  unpacked byte array, combinationally read.
- `id_ready`  in  1  decode can accept an instruction this cycle.
- `redirect`  in  1  taken branch/jump; flush and refetch.
- `redirect_pc`  in  32  new fetch address; sampled when `redirect`=1.
- `if_valid`  out  1  `instruction`/`instruction_pc` hold a valid entry.
- `instruction`  out  32  fetched instruction word.
- `instruction_pc`  out  32  address of `instruction`.
- `pc_plus4`  out  32  `instruction_pc` + 4.
- `nop_run`  out  3  consecutive 32'h0 instructions accepted by decode; saturates at 7.

## Operation

- Word assembly: `word = {mem[a+3], mem[a+2], mem[a+1], mem[a]}` with `a = fetch_pc mod MEM_BYTES`. Each byte index wraps mod MEM_BYTES independently. Example: bytes [3..0] = 20,0a,00,0a give 32'h200a_000a.
- Fetch: each cycle, if FIFO not full, or full and being popped this cycle, push {word, fetch_pc} and advance fetch_pc += 4. fetch_pc is a full 32-bit counter; only memory indexing wraps.
- Pop: a transfer occurs when `if_valid` && `id_ready`. Head advances at the same edge.
- Outputs are driven from the FIFO head. When empty, `if_valid`=0 and `instruction`, `instruction_pc`, `pc_plus4` hold their last values.
- Redirect, highest priority:
  - FIFO is emptied at the edge.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; low bits are forced to zero.
  - No push occurs that cycle.
  - A pop coinciding with `redirect` still counts as accepted and updates `nop_run`.
- `nop_run`:
  - On each transfer of 32'h0, increments, saturating at 7.
  - On transfer of any other word, resets to 0.
  - Unchanged when no transfer occurs.
- States:
  - RESET: async, reset=0.
  - RUN: free-running fetch.
  - STALLED: full, no pop, fetch_pc frozen.
  - FLUSH: single-cycle effect of `redirect`; not a separate held state, returns to RUN next edge.

## Timing

- Reset (async assert, any time):
  - fetch_pc = RESET_PC, FIFO empty, `if_valid`=0, `instruction`=0, `instruction_pc`=0, `pc_plus4`=4, `nop_run`=0.
  - Mid-operation reset discards all entries immediately.
- First rising edge with reset=1: pushes word @RESET_PC. `if_valid`=1 after that edge. Fetch-to-visible latency is 1 cycle.
- `id_ready` held high: one instruction per cycle, PCs RESET_PC, +4, +8, … with no bubbles.
- `id_ready` low: FIFO fills after FIFO_DEPTH edges, then fetch_pc freezes. Outputs remain stable while `if_valid` && !`id_ready`.
- Full with a pop on the same edge: push and pop both occur; occupancy unchanged.
- Redirect at edge N: `if_valid`=0 after N. Word @redirect target is visible after edge N+1.
- Empty with `redirect`=0: push at next edge; no combinational bypass.

## Test plan

- Reset then run with `id_ready`=1. mem[3..0]=20,0a,00,0a and mem[7..4]=20,0c,00,0b → cycle 1 `instruction`=32'h200a000a, PC 0; cycle 2 32'h200c000b, PC 4, `pc_plus4`=8.
- Hold `id_ready`=0 for 5 cycles after reset → `if_valid`=1, `instruction_pc` stays 0, fetch_pc stops at 8 (DEPTH=2). Release → PCs 0,4,8,12 on consecutive cycles.
- Assert `redirect` with `redirect_pc`=32'h2A while entries are buffered → next cycle `if_valid`=0; following cycle `instruction_pc`=32'h28 with the word at bytes 43..40.
- Fetch at PC 252 with MEM_BYTES=256 → word from bytes 255..252. Next `instruction_pc`=256 reads bytes 3..0.
- Four zero words accepted in a row → `nop_run`=4. Eight in a row → 7 (saturated). Then 32'h012a5820 accepted → 0.
- Assert reset low mid-stream between edges → outputs go to reset values immediately. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, assembles words from the byte
// memory and buffers them in a small prefetch FIFO toward decode.
module instr_fetch_stage #(
    parameter int          MEM_BYTES  = 256,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  instruction_mem [MEM_BYTES],
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] instruction,
    output logic [31:0] instruction_pc,
    output logic [31:0] pc_plus4,
    output logic [2:0]  nop_run
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [AW-1:0] a0, a1, a2, a3;
    logic [31:0]   word;

    logic [31:0]   fifo_word [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    logic [31:0]   last_word, last_pc;
    logic [31:0]   head_word, head_pc;
    logic          empty, full, pop, push;
    logic          unused_ok;

    // Each byte index wraps on its own, so a word may straddle the top.
    assign a0   = fetch_pc[AW-1:0];
    assign a1   = a0 + AW'(1);
    assign a2   = a0 + AW'(2);
    assign a3   = a0 + AW'(3);
    assign word = {instruction_mem[a3], instruction_mem[a2],
                   instruction_mem[a1], instruction_mem[a0]};

    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign pop       = !empty && id_ready;
    assign push      = !redirect && (!full || pop);
    assign head_word = fifo_word[rd_ptr];
    assign head_pc   = fifo_pc[rd_ptr];

    assign if_valid       = !empty;
    assign instruction    = empty ? last_word : head_word;
    assign instruction_pc = empty ? last_pc : head_pc;
    assign pc_plus4       = instruction_pc + 32'd4;
    assign unused_ok      = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word[wr_ptr] <= word;
            fifo_pc[wr_ptr]   <= fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc  <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            last_word <= '0;
            last_pc   <= '0;
            nop_run   <= '0;
        end else begin
            if (!empty) begin
                last_word <= head_word;
                last_pc   <= head_pc;
            end
            if (pop) begin
                if (head_word == 32'h0)
                    nop_run <= (nop_run == 3'd7) ? 3'd7 : nop_run + 3'd1;
                else
                    nop_run <= '0;
            end
            // Redirect wins over push/pop bookkeeping.
            if (redirect) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + PW'(1);
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)
                    count <= count + CW'(1);
                else if (pop && !push)
                    count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: stream, stall, redirect,
// memory wrap, nop counter and asynchronous reset.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  mem [256];
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] instruction;
    logic [31:0] instruction_pc;
    logic [31:0] pc_plus4;
    logic [2:0]  nop_run;

    int total = 0;
    int bad   = 0;

    instr_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .instruction_mem(mem),
        .id_ready       (id_ready),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .instruction    (instruction),
        .instruction_pc (instruction_pc),
        .pc_plus4       (pc_plus4),
        .nop_run        (nop_run)
    );

    always #5 clk = ~clk;

    task automatic do_reset(input logic rdy);
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = rdy;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        total++;
        if (if_valid !== 1'b0 || instruction !== 32'h0 ||
            instruction_pc !== 32'h0 || pc_plus4 !== 32'h4 ||
            nop_run !== 3'd0) begin
            bad++;
            $display("FAIL %s: v=%b i=%h pc=%h p4=%h n=%0d want 0/0/0/4/0",
                     tag, if_valid, instruction, instruction_pc,
                     pc_plus4, nop_run);
        end
    endtask

    task automatic test_reset;
        reset    = 1'b0;
        id_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        #1;
        check_reset_vals("reset_state");
        @(negedge clk);
        check_reset_vals("reset_held");
    endtask

    task automatic test_stream;
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h200a000a;
        exp_w[1] = 32'h200c000b;
        exp_w[2] = 32'h5049423b;
        exp_w[3] = 32'h6c655e57;
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (if_valid !== 1'b1 || instruction !== exp_w[i] ||
                instruction_pc !== 32'(4 * i) ||
                pc_plus4 !== 32'(4 * i + 4)) begin
                bad++;
                $display("FAIL stream%0d: v=%b i=%h pc=%h p4=%h want i=%h pc=%h",
                         i, if_valid, instruction, instruction_pc, pc_plus4,
                         exp_w[i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall;
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (if_valid !== 1'b1 || instruction_pc !== 32'h0 ||
                instruction !== 32'h200a000a) begin
                bad++;
                $display("FAIL stall%0d: v=%b pc=%h i=%h want 1/0/200a000a",
                         i, if_valid, instruction_pc, instruction);
            end
        end
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (if_valid !== 1'b1 || instruction_pc !== 32'(4 * i)) begin
                bad++;
                $display("FAIL release%0d: v=%b pc=%h want pc=%h",
                         i, if_valid, instruction_pc, 32'(4 * i));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect;
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h0000002a;
        @(negedge clk);
        redirect = 1'b0;
        total++;
        if (if_valid !== 1'b0 || instruction_pc !== 32'h0) begin
            bad++;
            $display("FAIL redir_flush: v=%b pc=%h want 0/00000000",
                     if_valid, instruction_pc);
        end
        @(negedge clk);
        total++;
        if (if_valid !== 1'b1 || instruction_pc !== 32'h28 ||
            instruction !== 32'h12345678) begin
            bad++;
            $display("FAIL redir_target: v=%b pc=%h i=%h want 1/28/12345678",
                     if_valid, instruction_pc, instruction);
        end
    endtask

    task automatic test_wrap;
        do_reset(1'b1);
        redirect    = 1'b1;
        redirect_pc = 32'h000000fc;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk);
        total++;
        if (instruction_pc !== 32'hfc || instruction !== 32'h11223344) begin
            bad++;
            $display("FAIL wrap_top: pc=%h i=%h want fc/11223344",
                     instruction_pc, instruction);
        end
        @(negedge clk);
        total++;
        if (instruction_pc !== 32'h100 || instruction !== 32'h200a000a ||
            pc_plus4 !== 32'h104) begin
            bad++;
            $display("FAIL wrap_low: pc=%h i=%h p4=%h want 100/200a000a/104",
                     instruction_pc, instruction, pc_plus4);
        end
    endtask

    task automatic test_nop;
        do_reset(1'b1);
        redirect    = 1'b1;
        redirect_pc = 32'h00000060;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk);
        total++;
        if (nop_run !== 3'd0 || instruction_pc !== 32'h60) begin
            bad++;
            $display("FAIL nop_start: n=%0d pc=%h want 0/60",
                     nop_run, instruction_pc);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 4) begin
                total++;
                if (nop_run !== 3'd4) begin
                    bad++;
                    $display("FAIL nop_four: n=%0d want 4", nop_run);
                end
            end
        end
        total++;
        if (nop_run !== 3'd7 || instruction !== 32'h012a5820) begin
            bad++;
            $display("FAIL nop_sat: n=%0d i=%h want 7/012a5820",
                     nop_run, instruction);
        end
        @(negedge clk);
        total++;
        if (nop_run !== 3'd0) begin
            bad++;
            $display("FAIL nop_clear: n=%0d want 0", nop_run);
        end
    endtask

    task automatic test_midreset;
        do_reset(1'b1);
        redirect    = 1'b1;
        redirect_pc = 32'h00000060;
        @(negedge clk);
        redirect = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (nop_run !== 3'd2) begin
            bad++;
            $display("FAIL mid_pre: n=%0d want 2", nop_run);
        end
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (if_valid !== 1'b1 || instruction_pc !== 32'h0 ||
            instruction !== 32'h200a000a) begin
            bad++;
            $display("FAIL mid_restart: v=%b pc=%h i=%h want 1/0/200a000a",
                     if_valid, instruction_pc, instruction);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'h0a; mem[1] = 8'h00; mem[2] = 8'h0a; mem[3] = 8'h20;
        mem[4] = 8'h0b; mem[5] = 8'h00; mem[6] = 8'h0c; mem[7] = 8'h20;
        mem[40] = 8'h78; mem[41] = 8'h56; mem[42] = 8'h34; mem[43] = 8'h12;
        for (int i = 8'h60; i < 8'h80; i++)
            mem[i] = 8'h00;
        mem[128] = 8'h20; mem[129] = 8'h58;
        mem[130] = 8'h2a; mem[131] = 8'h01;
        mem[252] = 8'h44; mem[253] = 8'h33;
        mem[254] = 8'h22; mem[255] = 8'h11;

        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_nop();
        test_midreset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
